inbuf_port_arbiter: RTL and testbench

- Shares the single-port input BRAM (inbuf_wrapper, 24-bit pixels, 1-cycle read latency) between two requesters.
- Requester 1 is the 3x3 window generator, which reads pixels. Requester 2 is the strip loader, which writes incoming pixel rows.
- Read traffic has fixed priority. The writer is guaranteed service after a bounded wait.
- Sits between Window3x3_RGB888/loader and inbuf_wrapper inside cnn_top. Read stalls appear to the window generator as a deasserted grant.

---
 rtl/inbuf_pkg.sv | 21 ++
 rtl/inbuf_port_arbiter_if.sv | 42 ++++
 rtl/inbuf_rd_pipe.sv | 44 ++++
 rtl/inbuf_port_arbiter.sv | 96 +++++++++
 tb/tb_inbuf_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inbuf_pkg.sv
// Shared definitions for the input-buffer arbiter slice.
// Holds the input BRAM geometry, the fixed read latency seen by the window generator,
// and the op encoding used by the grant logic.
package inbuf_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned WIDTH  = 480;
  localparam int unsigned HEIGHT = 5;
  localparam int unsigned DEPTH  = WIDTH * HEIGHT;

  // Handshake cycle to rd_valid cycle.
  localparam int unsigned RD_LAT = 3;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

endpackage

// File: rtl/inbuf_port_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the input BRAM.
// master: requester/BRAM side (drives requests, addresses, write data and mem_dout).
// slave : arbiter side (drives grants, read return, BRAM port and starve status).
//   rd_req/rd_addr/rd_gnt/rd_data/rd_valid : window generator read channel
//   wr_req/wr_addr/wr_data/wr_gnt          : strip loader write channel
//   mem_cs/mem_we/mem_addr/mem_din/mem_dout: single BRAM port
//   starve                                  : writer-forced arbitration active
interface inbuf_port_arbiter_if #(
  parameter int unsigned DATA_W = inbuf_pkg::DATA_W,
  parameter int unsigned ADDR_W = inbuf_pkg::ADDR_W
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              starve;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_dout,
    input  rd_gnt, rd_data, rd_valid, wr_gnt, mem_cs, mem_we, mem_addr, mem_din, starve
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_dout,
    output rd_gnt, rd_data, rd_valid, wr_gnt, mem_cs, mem_we, mem_addr, mem_din, starve
  );

endinterface

// File: rtl/inbuf_rd_pipe.sv
// Read return path: tracks accepted reads through the BRAM port and captures the pixel.
//   clk, rst : clock, asynchronous active-high reset (drops in-flight reads)
//   rd_fire  : a read transfer happens this cycle
//   mem_dout : BRAM read data
//   rd_data  : captured pixel, holds when rd_valid is low
//   rd_valid : one-cycle pulse per accepted read, RD_LAT cycles after rd_fire
module inbuf_rd_pipe #(
  parameter int unsigned DATA_W = inbuf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  import inbuf_pkg::*;

  // Flag stages cover the registered BRAM address cycle and the BRAM latency cycle;
  // the capture register supplies the last cycle.
  localparam int unsigned Stages = RD_LAT - 1;

  logic [Stages-1:0] flag_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      flag_q  <= (flag_q << 1) | Stages'(rd_fire);
      valid_q <= flag_q[Stages-1];
      if (flag_q[Stages-1]) begin
        data_q <= mem_dout;
      end
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/inbuf_port_arbiter.sv
// Shares the single-port input BRAM between the 3x3 window generator (reads, priority)
// and the strip loader (writes, forced through after STARVE_MAX+1 waiting cycles).
//   clk : single clock
//   rst : asynchronous active-high reset
//   bus : inbuf_port_arbiter_if.slave (read/write channels, BRAM port, starve status)
module inbuf_port_arbiter #(
  parameter int unsigned DATA_W     = inbuf_pkg::DATA_W,
  parameter int unsigned ADDR_W     = inbuf_pkg::ADDR_W,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  inbuf_port_arbiter_if.slave bus
);
  import inbuf_pkg::*;

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

  op_e               op;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              mem_cs_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    op = OP_IDLE;
    if (!rst) begin
      if (starve_q && bus.wr_req) begin
        op = OP_WR;
      end else if (bus.rd_req) begin
        op = OP_RD;
      end else if (bus.wr_req) begin
        op = OP_WR;
      end
    end
  end

  assign bus.rd_gnt = (op == OP_RD);
  assign bus.wr_gnt = (op == OP_WR);

  // Wait counter for a pending write. starve follows the counter by one cycle, so a
  // continuously waiting write is forced through on its STARVE_MAX+1'th cycle; it is
  // dropped as soon as that write goes through so a follow-up write gets no free pass.
  always_comb begin
    cnt_d = cnt_q;
    if (!bus.wr_req || bus.wr_gnt) begin
      cnt_d = '0;
    end else if (cnt_q < StarveMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    starve_d = (cnt_q == StarveMax) && bus.wr_req && !bus.wr_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      starve_q   <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      mem_cs_q <= (op != OP_IDLE);
      mem_we_q <= (op == OP_WR);
      if (op == OP_RD) begin
        mem_addr_q <= bus.rd_addr;
      end else if (op == OP_WR) begin
        mem_addr_q <= bus.wr_addr;
        mem_din_q  <= bus.wr_data;
      end
    end
  end

  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.starve   = starve_q;

  inbuf_rd_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .rd_fire  (bus.rd_gnt),
    .mem_dout (bus.mem_dout),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid)
  );

endmodule

// File: tb/tb_inbuf_port_arbiter.sv
// Bench for inbuf_port_arbiter: BRAM model, shadow-memory scoreboard for read returns
// (data and latency), a table of single-cycle arbitration vectors and hand-written
// sequences for reset, streaming, starvation, write-then-read and mid-operation reset.
module tb_inbuf_port_arbiter;
  import inbuf_pkg::*;

  localparam int unsigned STARVE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inbuf_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  inbuf_port_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks  = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;
  int unsigned n_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int unsigned a);
    if (a == 16) return 24'hA1B2C3;
    return DATA_W'(a * 32'h0001_0203 + 32'h000F_0F0F);
  endfunction

  function automatic int idx(input logic [ADDR_W-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  // BRAM model: 1-cycle read latency, strictly ordered single port.
  logic [DATA_W-1:0] bram [DEPTH];
  bit                bram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bram_loaded) begin
      for (int i = 0; i < DEPTH; i++) bram[i] = pat(i);
      bram_loaded = 1'b1;
    end
    if (bus.mem_cs) begin
      if (bus.mem_we) bram[idx(bus.mem_addr)] = bus.mem_din;
      else            bus.mem_dout <= bram[idx(bus.mem_addr)];
    end
  end

  // Scoreboard: expected pixel and due cycle pushed on each read handshake.
  typedef struct {
    logic [DATA_W-1:0] data;
    int unsigned       due;
  } exp_t;

  exp_t              sb [$];
  exp_t              mon_e;
  logic [DATA_W-1:0] shadow [DEPTH];
  bit                shadow_loaded = 1'b0;

  always @(negedge clk) begin
    if (!shadow_loaded) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
      shadow_loaded = 1'b1;
    end
    if (rst) begin
      sb.delete();
      check("rst_gnt", 32'({bus.rd_gnt, bus.wr_gnt}), 32'd0);
      check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    end else begin
      check("gnt_legal", 32'((bus.rd_gnt & ~bus.rd_req) | (bus.wr_gnt & ~bus.wr_req) |
                             (bus.rd_gnt & bus.wr_gnt)), 32'd0);
      if (bus.wr_req && bus.wr_gnt) shadow[idx(bus.wr_addr)] = bus.wr_data;
      if (bus.rd_req && bus.rd_gnt) begin
        sb.push_back('{data: shadow[idx(bus.rd_addr)], due: cyc + RD_LAT});
      end
      if (bus.rd_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          check("rd_valid_unexpected", 32'(bus.rd_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(mon_e.data));
          check("rd_latency", cyc, mon_e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at a drive point with rd_req and wr_req both high; the write must be
  // granted on the STARVE+1'th cycle, with the reader resuming right after.
  task automatic starve_run(input string tag);
    int got = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == STARVE) check({tag, "_starve_pre"}, 32'(bus.starve), 32'd0);
      if (bus.wr_gnt) begin
        got = k;
        check({tag, "_starve_at_gnt"}, 32'(bus.starve), 32'd1);
        check({tag, "_rd_gnt_blocked"}, 32'(bus.rd_gnt), 32'd0);
        break;
      end
      step();
      bus.rd_addr = ADDR_W'(k + 1);
    end
    check({tag, "_wr_gnt_wait"}, 32'(got), 32'(STARVE + 1));
    step();
    bus.wr_req  = 1'b0;
    bus.rd_addr = bus.rd_addr + 1'b1;
    @(negedge clk);
    check({tag, "_rd_resume"}, 32'(bus.rd_gnt), 32'd1);
    check({tag, "_starve_clear"}, 32'(bus.starve), 32'd0);
    step();
    bus.rd_req = 1'b0;
  endtask

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              g_rd;
    logic              g_wr;
  } vec_t;

  vec_t        vecs [7];
  int unsigned nv0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 17'd20,   17'd0,    24'h000000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 17'd0,    17'd30,   24'hABCDEF, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 17'd31,   17'd40,   24'h111111, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 17'd5,    17'd6,    24'h222222, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 17'd30,   17'd0,    24'h000000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 17'd0,    17'd2399, 24'h0000FF, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 17'd2399, 17'd0,    24'h000000, 1'b1, 1'b0};

    // Reset with both requests high: grants must stay low.
    bus.rd_req  = 1'b1;
    bus.wr_req  = 1'b1;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_din", 32'(bus.mem_din), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_starve", 32'(bus.starve), 32'd0);
    step();
    rst        = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_mem_cs", 32'(bus.mem_cs), 32'd0);
      check("idle_outputs", 32'({bus.mem_we, bus.rd_valid, bus.starve, bus.rd_gnt, bus.wr_gnt}),
            32'd0);
      step();
    end

    // Single read of the preloaded pixel at 0x10.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 17'h00010;
    @(negedge clk);
    check("single_rd_gnt", 32'({bus.rd_gnt, bus.wr_gnt}), 32'b10);
    step();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("single_mem_port", 32'({bus.mem_cs, bus.mem_we}), 32'b10);
    check("single_mem_addr", 32'(bus.mem_addr), 32'h10);
    check("single_valid_t1", 32'(bus.rd_valid), 32'd0);
    step();
    @(negedge clk);
    check("single_valid_t2", 32'(bus.rd_valid), 32'd0);
    step();
    @(negedge clk);
    check("single_valid_t3", 32'(bus.rd_valid), 32'd1);
    check("single_data_t3", 32'(bus.rd_data), 32'hA1B2C3);
    step();
    @(negedge clk);
    check("single_valid_t4", 32'(bus.rd_valid), 32'd0);
    check("single_data_hold", 32'(bus.rd_data), 32'hA1B2C3);
    step();

    // Arbitration vectors: grant in the request cycle, BRAM port on the next.
    foreach (vecs[v]) begin
      bus.rd_req  = vecs[v].rd;
      bus.wr_req  = vecs[v].wr;
      bus.rd_addr = vecs[v].ra;
      bus.wr_addr = vecs[v].wa;
      bus.wr_data = vecs[v].wd;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", v), 32'({bus.rd_gnt, bus.wr_gnt}),
            32'({vecs[v].g_rd, vecs[v].g_wr}));
      step();
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_mem_cs_we", v), 32'({bus.mem_cs, bus.mem_we}),
            32'({vecs[v].g_rd | vecs[v].g_wr, vecs[v].g_wr}));
      if (vecs[v].g_rd) check($sformatf("vec%0d_rd_addr", v), 32'(bus.mem_addr), 32'(vecs[v].ra));
      if (vecs[v].g_wr) begin
        check($sformatf("vec%0d_wr_addr", v), 32'(bus.mem_addr), 32'(vecs[v].wa));
        check($sformatf("vec%0d_wr_din", v), 32'(bus.mem_din), 32'(vecs[v].wd));
      end
      step();
    end
    repeat (4) step();

    // One full row of back-to-back reads.
    nv0 = n_valid;
    for (int i = 0; i < WIDTH; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = ADDR_W'(i);
      @(negedge clk);
      check("stream_rd_gnt", 32'(bus.rd_gnt), 32'd1);
      step();
    end
    bus.rd_req = 1'b0;
    repeat (5) step();
    check("stream_valid_count", n_valid - nv0, WIDTH);

    // Writer against a continuous reader.
    bus.rd_req  = 1'b1;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 17'h00005;
    bus.wr_data = 24'h123456;
    starve_run("starve");
    repeat (4) step();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 17'h00005;
    step();
    bus.rd_req = 1'b0;
    repeat (5) step();

    // Write followed immediately by a read of the same address.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 17'd7;
    bus.wr_data = 24'h00FF00;
    @(negedge clk);
    check("wtr_wr_gnt", 32'(bus.wr_gnt), 32'd1);
    step();
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 17'd7;
    @(negedge clk);
    check("wtr_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    step();
    bus.rd_req = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("wtr_valid", 32'(bus.rd_valid), 32'd1);
    check("wtr_data", 32'(bus.rd_data), 32'h00FF00);
    step();
    repeat (3) step();

    // Three back-to-back reads with a waiting writer, then reset on the edge that
    // closes the third read: none of them may return, and the writer's wait restarts.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 17'd9;
    bus.wr_data = 24'h0BADC0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = ADDR_W'(100 + i);
      @(negedge clk);
      check("mid_rst_rd_gnt", 32'(bus.rd_gnt), 32'd1);
      if (i < 2) step();
    end
    @(posedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
      check("mid_rst_starve", 32'(bus.starve), 32'd0);
    end
    step();
    rst = 1'b0;
    starve_run("post_rst");
    repeat (6) step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
